// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: data width, register and requester indices, wrap helper
package cpu_pkg;

    localparam int DATA_W = 8;

    localparam int REG_A = 0;
    localparam int REG_B = 1;
    localparam int REG_C = 2;
    localparam int REG_D = 3;

    localparam int REQ_ALU  = 0;
    localparam int REQ_MEM  = 1;
    localparam int REQ_CTRL = 2;
    localparam int REQ_DBG  = 3;

    // Modulo-n increment by compare, so non-power-of-two counts wrap correctly.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// rtl/reg_write_arbiter_rr_pick.sv - combinational round-robin selector, first eligible at or after ptr
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         eligible_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [$clog2(N)-1:0] g_o,
    output logic                 found_o
);
    import cpu_pkg::*;

    localparam int PTR_W = $clog2(N);

    logic [PTR_W-1:0] idx;

    always_comb begin
        g_o     = '0;
        found_o = 1'b0;
        idx     = ptr_i;
        for (int k = 0; k < N; k++) begin
            if (!found_o && eligible_i[idx]) begin
                g_o     = idx;
                found_o = 1'b1;
            end
            idx = PTR_W'(rr_next(32'(idx), N));
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter sharing the register bank write port
module reg_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int NUM_REG = 4,
    parameter int DATA_W  = 8
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic [NUM_REQ-1:0]                   req,
    input  logic [NUM_REQ*$clog2(NUM_REG)-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]            req_data,
    output logic [NUM_REQ-1:0]                   ack,
    output logic [DATA_W-1:0]                    wr_data,
    output logic [NUM_REG-1:0]                   wr_load,
    output logic [$clog2(NUM_REQ)-1:0]           grant_id,
    output logic                                 busy
);
    import cpu_pkg::*;

    localparam int ADDR_W = $clog2(NUM_REG);
    localparam int GID_W  = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REG-1:0] wr_load_q, wr_load_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [GID_W-1:0]   grant_id_q, grant_id_d;
    logic [GID_W-1:0]   ptr_q, ptr_d;

    logic [NUM_REQ-1:0] eligible;
    logic [GID_W-1:0]   g;
    logic               found;
    logic [ADDR_W-1:0]  addr_sel;

    // A requester acked this cycle is masked so its held request is not granted twice.
    assign eligible = req & ~ack_q;

    rr_pick #(
        .N(NUM_REQ)
    ) u_pick (
        .eligible_i(eligible),
        .ptr_i     (ptr_q),
        .g_o       (g),
        .found_o   (found)
    );

    assign addr_sel = req_addr[g*ADDR_W +: ADDR_W];

    always_comb begin
        ack_d      = '0;
        wr_load_d  = '0;
        wr_data_d  = wr_data_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        if (enable && found) begin
            ack_d[g]   = 1'b1;
            grant_id_d = g;
            wr_data_d  = req_data[g*DATA_W +: DATA_W];
            ptr_d      = GID_W'(rr_next(32'(g), NUM_REQ));
            // Indices past the bank decode to no strobe: the write is dropped but still acked.
            for (int r = 0; r < NUM_REG; r++) begin
                wr_load_d[r] = (addr_sel == ADDR_W'(r));
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ack_q      <= '0;
            wr_load_q  <= '0;
            wr_data_q  <= '0;
            grant_id_q <= '0;
            ptr_q      <= '0;
        end else begin
            ack_q      <= ack_d;
            wr_load_q  <= wr_load_d;
            wr_data_q  <= wr_data_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
        end
    end

    assign ack      = ack_q;
    assign wr_load  = wr_load_q;
    assign wr_data  = wr_data_q;
    assign grant_id = grant_id_q;
    assign busy     = |eligible;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed self-checking bench for reg_write_arbiter
module tb_reg_write_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  req;
    logic [7:0]  req_addr;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [7:0]  wr_data;
    logic [3:0]  wr_load;
    logic [1:0]  grant_id;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] regs [4];

    reg_write_arbiter #(
        .NUM_REQ(4),
        .NUM_REG(4),
        .DATA_W (8)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .req     (req),
        .req_addr(req_addr),
        .req_data(req_data),
        .ack     (ack),
        .wr_data (wr_data),
        .wr_load (wr_load),
        .grant_id(grant_id),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    // Register bank model fed by the arbiter's strobes.
    always @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_load[i]) regs[i] <= wr_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [1:0] addr, input logic [7:0] data);
        req_addr[i*2 +: 2] = addr;
        req_data[i*8 +: 8] = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic prev_load;

        // 1: reset overrides pending requests, then idle
        reset = 1'b1; enable = 1'b1; req = 4'b1111; req_addr = '0; req_data = '0;
        step();
        step();
        chk("rst_ack", ack, 4'b0000);
        chk("rst_load", wr_load, 4'b0000);
        chk("rst_data", wr_data, 8'h00);
        chk("rst_gid", grant_id, 2'd0);
        reset = 1'b0; req = 4'b0000;
        step();
        chk("idle_ack", ack, 4'b0000);
        chk("idle_load", wr_load, 4'b0000);
        chk("idle_busy", busy, 1'b0);

        // 2: single request from requester 1 to register 2
        set_slot(cpu_pkg::REQ_MEM, 2'd2, 8'h92);
        req = 4'b0010;
        #1;
        chk("single_busy_pre", busy, 1'b1);
        step();
        chk("single_ack", ack, 4'b0010);
        chk("single_gid", grant_id, 2'd1);
        chk("single_load", wr_load, 4'b0100);
        chk("single_data", wr_data, 8'h92);
        req = 4'b0000;
        step();
        chk("single_ack_off", ack, 4'b0000);
        chk("single_load_off", wr_load, 4'b0000);
        chk("single_data_hold", wr_data, 8'h92);
        chk("single_reg2", regs[2], 8'h92);

        // 3: all four held from reset -> 0,1,2,3,0,1,2,3
        for (int i = 0; i < 4; i++) set_slot(i, 2'(i), 8'h10 + 8'(i));
        reset = 1'b1; req = 4'b1111;
        step();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("rr_ack%0d", k), ack, 4'b0001 << (k % 4));
            chk($sformatf("rr_gid%0d", k), grant_id, k % 4);
            chk($sformatf("rr_load%0d", k), wr_load, 4'b0001 << (k % 4));
            chk($sformatf("rr_data%0d", k), wr_data, 8'h10 + (k % 4));
        end

        // 4: lone held request is granted every other cycle
        reset = 1'b1; req = 4'b0000;
        step();
        reset = 1'b0;
        set_slot(cpu_pkg::REQ_DBG, 2'd3, 8'hF0);
        req = 4'b1000;
        pulses = 0;
        prev_load = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("self_ack%0d", k), ack, (k % 2 == 0) ? 4'b1000 : 4'b0000);
            chk($sformatf("self_busy%0d", k), busy, (k % 2 == 0) ? 1'b0 : 1'b1);
            chk($sformatf("self_b2b%0d", k), 32'(prev_load & (|wr_load)), 32'd0);
            if (ack[3]) pulses++;
            prev_load = |wr_load;
        end
        chk("self_pulses", pulses, 3);
        chk("self_data", wr_data, 8'hF0);
        req = 4'b0000;
        step();

        // 5: freeze with pending requests, then resume 0 then 2
        set_slot(cpu_pkg::REQ_ALU, 2'd1, 8'hA1);
        set_slot(cpu_pkg::REQ_CTRL, 2'd0, 8'hC2);
        enable = 1'b0; req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("frz_ack%0d", k), ack, 4'b0000);
            chk($sformatf("frz_busy%0d", k), busy, 1'b1);
            chk($sformatf("frz_load%0d", k), wr_load, 4'b0000);
        end
        enable = 1'b1;
        step();
        chk("res_ack0", ack, 4'b0001);
        chk("res_load0", wr_load, 4'b0010);
        chk("res_data0", wr_data, 8'hA1);
        req = 4'b0100;
        step();
        chk("res_ack2", ack, 4'b0100);
        chk("res_gid2", grant_id, 2'd2);
        chk("res_load2", wr_load, 4'b0001);
        chk("res_data2", wr_data, 8'hC2);
        chk("res_reg1", regs[1], 8'hA1);
        req = 4'b0000;
        step();
        chk("res_idle", ack, 4'b0000);
        chk("res_reg0", regs[0], 8'hC2);

        // 6: reset in the cycle requester 2 would win; ptr must return to 0
        set_slot(cpu_pkg::REQ_DBG, 2'd3, 8'h33);
        set_slot(cpu_pkg::REQ_CTRL, 2'd2, 8'h22);
        reset = 1'b1; req = 4'b0100;
        step();
        chk("mid_ack", ack, 4'b0000);
        chk("mid_load", wr_load, 4'b0000);
        chk("mid_data", wr_data, 8'h00);
        chk("mid_gid", grant_id, 2'd0);
        reset = 1'b0; req = 4'b1100;
        step();
        chk("post_ack", ack, 4'b0100);
        chk("post_gid", grant_id, 2'd2);
        chk("post_data", wr_data, 8'h22);
        req = 4'b1000;
        step();
        chk("post_ack3", ack, 4'b1000);
        chk("post_load3", wr_load, 4'b1000);
        req = 4'b0000;
        step();
        chk("end_ack", ack, 4'b0000);
        chk("end_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the single write path into the CPU register bank (NUM_REG 8-bit Register instances) between NUM_REQ requesters, e.g. ALU writeback, memory load, immediate/control unit and debug port.
- Grants one request per cycle, round-robin.
- Drives the registered write data bus and one-hot load strobes that go straight to each Register's IN/load pins.
- Returns a one-cycle ack to the winning requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_REG, 4, number of registers in the bank (2..16).
- DATA_W, 8, register data width.
- ADDR_W, derived localparam = clog2(NUM_REG), register index width; not overridable.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = arbitrate; 0 = freeze, no new grants.
- req  in  NUM_REQ  per-requester write request, level; held until acked.
- req_addr  in  NUM_REQ*ADDR_W  flattened target register index; slice i belongs to requester i.
- req_data  in  NUM_REQ*DATA_W  flattened write data; slice i belongs to requester i.
- ack  out  NUM_REQ  one-hot, one-cycle pulse to the granted requester.
- wr_data  out  DATA_W  data to all Register IN pins.
- wr_load  out  NUM_REG  one-hot load strobe to Register i.
- grant_id  out  clog2(NUM_REQ)  index of the requester acked this cycle; valid when |ack.
- busy  out  1  1 when any req is pending and not yet acked.

Behaviour:
- Reset (reset=1 at a rising edge):
  - ack=0, wr_load=0, wr_data=0, grant_id=0, priority pointer ptr=0.
  - Reset overrides everything. A grant being computed in that cycle is discarded, with no ack and no load. Requests must be re-presented and are re-arbitrated after reset deasserts.
- Eligibility in cycle t: eligible[i] = req[i] & ~ack[i]. A requester whose ack is high this cycle is masked, so one request is never granted twice. Back-to-back requests from one requester are therefore granted at most every other cycle.
- Selection (combinational): g = first eligible index searching ptr, ptr+1, … NUM_REQ-1, 0, … ptr-1.
- Registered outputs, at the edge ending cycle t, if enable=1 and any eligible requester exists:
  - ack <= onehot(g); grant_id <= g.
  - wr_data <= req_data[g].
  - wr_load <= onehot(req_addr[g]).
  - ptr <= (g+1) mod NUM_REQ.
- Idle update: if enable=0 or no requester is eligible, ack <= 0 and wr_load <= 0; wr_data and ptr hold.
- Latency:
  - req sampled at edge E; ack and wr_load high during E..E+1.
  - The Register captures wr_data at E+1, i.e. 2 edges from request to register update at best.
- Handshake: the requester holds req/addr/data stable until it sees ack=1. It may drop req, or present a new transaction, at the next edge.
- Out-of-range req_addr (>= NUM_REG, only possible if NUM_REG is not a power of two):
  - The grant and ack still happen, wr_load=0, so the write is dropped silently.
  - The requester is still considered served.
- Two requesters targeting the same register: serialized by arbitration order; the later-granted write wins.
- enable falling while requests are pending: no new grants. An ack/wr_load already registered completes its one cycle. ptr holds, and arbitration resumes from ptr when enable returns.
- busy = |(req & ~ack), combinational.
- Widths: all indices are unsigned. ptr wrap uses explicit compare-to-(NUM_REQ-1), not a power-of-two mask.

Decomposition:
- Shared package (cpu_pkg): DATA_W=8 constant, register-index constants (REG_A=0, REG_B=1, …), requester IDs (REQ_ALU=0, REQ_MEM=1, REQ_CTRL=2, REQ_DBG=3).
- Sub-module: rr_pick (combinational round-robin selector). Inputs eligible and ptr; outputs g and a found flag. Kept separate so it can be reused by a future memory-port arbiter.
- reg_write_arbiter holds the registers, masking and output muxing.

Test Plan:
1. Reset and idle: hold reset=1 for 2 edges with req=4'b1111 -> ack=0, wr_load=0, wr_data=0. After release with no req -> outputs stay 0 and busy=0.
2. Single request: req[1]=1, addr=2, data=8'h92, held until ack -> next edge ack=4'b0010, grant_id=1, wr_load=4'b0100, wr_data=8'h92 for exactly 1 cycle. Register 2 reads 8'h92 one edge later.
3. Round-robin fairness: all 4 req held continuously from reset, each acked then re-requesting at once -> grant order 0,1,2,3,0,… with no requester granted twice in a row while others wait.
4. Self-mask: only req[3] held high for 6 cycles, data=8'hF0 -> ack[3] pulses every other cycle (3 pulses). wr_load never high in two consecutive cycles.
5. Enable freeze: req=4'b0101, enable=0 for 4 cycles -> no ack and busy=1. Enable=1 -> grant 0 then 2, with ptr preserved across the freeze.
6. Reset mid-operation: reset asserted in the cycle req[2] would win -> no ack[2] and no wr_load that cycle, ptr=0. After release, req[2] is granted on the first enabled edge.
